// File: rtl/btn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_pkg: state encoding and constant helpers shared by the button blocks
// Rev 1.0
// ----------------------------------------------------------------------------
package btn_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PRESS1   = 3'd1;
  localparam logic [2:0] LONG     = 3'd2;
  localparam logic [2:0] WAIT2    = 3'd3;
  localparam logic [2:0] WAIT_REL = 3'd4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tick_gen: free-running prescaler, one-cycle tick every DIV clocks
// Rev 1.0
// ----------------------------------------------------------------------------
module tick_gen
  import btn_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            PW       = clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule
`default_nettype wire

// File: rtl/press_classifier.sv
`default_nettype none
// ----------------------------------------------------------------------------
// press_classifier: debounced level -> short / long / double press events
// Rev 1.0
// ----------------------------------------------------------------------------
module press_classifier
  import btn_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 1000,
  parameter int DOUBLE_TICKS = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held
);

  localparam int            MAXT        = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
  localparam int            CW          = clog2(MAXT + 1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_TICKS - 1);

  logic          tick;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic          held_q, held_d;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Release and second press are tested first so they win over a coincident tick.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE:     if (db) state_d = PRESS1;
      PRESS1: begin
        if (!db) begin
          state_d = WAIT2;
        end else if (tick && cnt_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      LONG:     if (!db) state_d = IDLE;
      WAIT2: begin
        if (db) begin
          state_d  = WAIT_REL;
          double_d = 1'b1;
        end else if (tick && cnt_q == DOUBLE_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      WAIT_REL: if (!db) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    held_d = (state_d == LONG);

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick && (state_q == PRESS1 || state_q == WAIT2) && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign held         = held_q;

endmodule
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_press_classifier: directed stimulus with a queue-based event scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_press_classifier;

  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 10;
  localparam int DOUBLE_TICKS = 5;

  localparam int K_SHORT  = 0;
  localparam int K_LONG   = 1;
  localparam int K_DOUBLE = 2;

  typedef struct {
    int kind;
    int lo;
    int hi;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic db    = 1'b0;
  logic short_press;
  logic long_press;
  logic double_press;
  logic held;

  exp_t sb[$];
  int   cyc;
  int   tests = 0;
  int   fails = 0;

  press_classifier #(
    .TICK_DIV     (TICK_DIV),
    .LONG_TICKS   (LONG_TICKS),
    .DOUBLE_TICKS (DOUBLE_TICKS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .db           (db),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Edge index since reset release; the prescaler ticks on every edge where cyc % TICK_DIV == 0.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin : monitor
    int   n;
    int   k;
    exp_t x;
    if (!reset) begin
      if (sb.size() > 0 && cyc > sb[0].hi) begin
        tests++;
        fails++;
        $display("FAIL missed_event kind=%0d window=%0d..%0d now=%0d", sb[0].kind, sb[0].lo, sb[0].hi, cyc);
        void'(sb.pop_front());
      end
      n = int'(short_press) + int'(long_press) + int'(double_press);
      if (long_press) begin
        tests++;
        if (held !== 1'b1) begin
          fails++;
          $display("FAIL held_with_long actual=%b required=1", held);
        end
      end
      if (n > 1) begin
        tests++;
        fails++;
        $display("FAIL onehot actual=%b%b%b required at most one high (cycle %0d)",
                 short_press, long_press, double_press, cyc);
      end else if (n == 1) begin
        k = short_press ? K_SHORT : (long_press ? K_LONG : K_DOUBLE);
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse actual kind=%0d at cycle %0d required none", k, cyc);
        end else begin
          x = sb.pop_front();
          if (k != x.kind || cyc < x.lo || cyc > x.hi) begin
            fails++;
            $display("FAIL event actual kind=%0d cycle=%0d required kind=%0d cycle=%0d..%0d",
                     k, cyc, x.kind, x.lo, x.hi);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called just after a falling edge; returns the edge index that samples the new level.
  task automatic drive(input logic v, output int e);
    db = v;
    e  = cyc + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  function automatic int next_tick_after(input int edge_idx);
    return ((edge_idx / TICK_DIV) + 1) * TICK_DIV;
  endfunction

  initial begin
    int e;
    int r;
    int t;

    #12;
    check("reset_outputs", {28'd0, short_press, long_press, double_press, held}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Async reset while in PRESS1, button released under reset: nothing may follow.
    drive(1'b1, e);
    cycles(5);
    #2 reset = 1'b1;
    #1 check("async_reset_press1", {28'd0, short_press, long_press, double_press, held}, 32'd0);
    db = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(40);

    // Short press: 20 cycles held.
    drive(1'b1, e);
    cycles(20);
    drive(1'b0, r);
    sb.push_back('{K_SHORT, r + 17, r + 20});
    cycles(30);

    // Long press: 60 cycles held.
    drive(1'b1, e);
    sb.push_back('{K_LONG, e + 37, e + 40});
    cycles(60);
    check("held_in_long", {31'd0, held}, 32'd1);
    drive(1'b0, r);
    @(negedge clk);
    check("held_after_release", {31'd0, held}, 32'd0);
    cycles(30);

    // Double press: high 8, low 6, high 8, low.
    drive(1'b1, e);
    cycles(8);
    drive(1'b0, r);
    cycles(6);
    drive(1'b1, e);
    sb.push_back('{K_DOUBLE, e, e});
    cycles(8);
    drive(1'b0, r);
    cycles(30);

    // Second rise sampled on the exact WAIT2 timeout tick.
    drive(1'b1, e);
    cycles(8);
    drive(1'b0, r);
    t = next_tick_after(r) + (DOUBLE_TICKS - 1) * TICK_DIV;
    wait_until(t - 1);
    drive(1'b1, e);
    sb.push_back('{K_DOUBLE, t, t});
    cycles(8);
    drive(1'b0, r);
    cycles(30);

    // Release sampled on the exact long-threshold tick.
    drive(1'b1, e);
    t = next_tick_after(e) + (LONG_TICKS - 1) * TICK_DIV;
    wait_until(t - 1);
    drive(1'b0, r);
    sb.push_back('{K_SHORT, t + 17, t + 20});
    cycles(30);

    // Async reset while held in LONG drops held immediately.
    drive(1'b1, e);
    sb.push_back('{K_LONG, e + 37, e + 40});
    cycles(45);
    check("held_before_reset", {31'd0, held}, 32'd1);
    #2 reset = 1'b1;
    #1 check("async_reset_long", {28'd0, short_press, long_press, double_press, held}, 32'd0);
    db = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(30);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
